rgb_pwm_driver: RTL and testbench



---
 rtl/rgb_pwm_pkg.sv | 14 +
 rtl/pwm_channel.sv | 44 ++++
 rtl/rgb_pwm_driver.sv | 90 +++++++++
 tb/tb_rgb_pwm_driver.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared widths and channel indices for the RGB PWM driver.
package rgb_pwm_pkg;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] PWM_MAX = 8'd255;

  // Channel index, used to address the per-channel duty and pin vectors.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_idx_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register, comparator against the shared
// step counter, and a registered output pin.
module pwm_channel
  import rgb_pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             track,
  input  logic [PWM_W-1:0] cnt,
  input  logic [PWM_W-1:0] duty,
  output logic             pin
);

  logic [PWM_W-1:0] shadow_d, shadow_q;
  logic             pin_d, pin_q;

  // Shadow follows the input while disabled and otherwise only at period end,
  // so a running period always finishes with the duty it started with.
  always_comb begin
    shadow_d = shadow_q;
    if (track || load) begin
      shadow_d = duty;
    end
    pin_d = (en && (cnt < shadow_q)) ^ ACTIVE_LOW;
  end

  // Shadow and pin registers; reset leaves the pin at its inactive level.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      pin_q    <= ACTIVE_LOW;
    end else begin
      shadow_q <= shadow_d;
      pin_q    <= pin_d;
    end
  end

  assign pin = pin_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: shared prescaler and 8-bit step counter feeding three
// pwm_channel instances, plus a period_start marker aligned with step 0.
module rgb_pwm_driver
  import rgb_pwm_pkg::*;
#(
  parameter int unsigned PRESC_DIV  = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PWM_W-1:0] R_time_in,
  input  logic [PWM_W-1:0] G_time_in,
  input  logic [PWM_W-1:0] B_time_in,
  output logic             R_out,
  output logic             G_out,
  output logic             B_out,
  output logic             period_start
);

  localparam logic [15:0] PRE_LAST = 16'(PRESC_DIV - 1);

  logic [15:0]      pre_d, pre_q;
  logic [PWM_W-1:0] cnt_d, cnt_q;
  logic             ps_d, ps_q;
  logic             tick;
  logic             load;
  logic             track;

  logic [PWM_W-1:0] duty [3];
  logic [2:0]       pins;

  // Prescaler, step counter and period marker; disable parks everything at 0
  // so re-enabling always starts a fresh period.
  always_comb begin
    tick  = en && (pre_q == PRE_LAST);
    load  = tick && (cnt_q == PWM_MAX);
    track = !en;
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!en) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    ps_d = en && (cnt_q == '0) && (pre_q == '0);
  end

  // Counter state registers.
  always_ff @(posedge div_clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  assign duty[int'(CH_R)] = R_time_in;
  assign duty[int'(CH_G)] = G_time_in;
  assign duty[int'(CH_B)] = B_time_in;

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    pwm_channel #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk  (div_clk),
      .rst  (rst),
      .en   (en),
      .load (load),
      .track(track),
      .cnt  (cnt_q),
      .duty (duty[ch]),
      .pin  (pins[ch])
    );
  end

  assign R_out        = pins[int'(CH_R)];
  assign G_out        = pins[int'(CH_G)];
  assign B_out        = pins[int'(CH_B)];
  assign period_start = ps_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: dut_a (PRESC_DIV=1, active-high) and
// dut_b (PRESC_DIV=4, active-low) share the same input stimulus.
module tb_rgb_pwm_driver;

  logic       div_clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] r_in, g_in, b_in;
  logic       ra, ga, ba, psa;
  logic       rb, gb, bb, psb;

  int checks   = 0;
  int failures = 0;

  // Clock.
  always #5 div_clk = ~div_clk;

  rgb_pwm_driver #(.PRESC_DIV(1), .ACTIVE_LOW(1'b0)) dut_a (
    .div_clk(div_clk), .rst(rst), .en(en),
    .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .R_out(ra), .G_out(ga), .B_out(ba), .period_start(psa)
  );

  rgb_pwm_driver #(.PRESC_DIV(4), .ACTIVE_LOW(1'b1)) dut_b (
    .div_clk(div_clk), .rst(rst), .en(en),
    .R_time_in(r_in), .G_time_in(g_in), .B_time_in(b_in),
    .R_out(rb), .G_out(gb), .B_out(bb), .period_start(psb)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge div_clk);
    #1;
  endtask

  task automatic wait_ps(input bit sel, input int budget, output int ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if ((sel ? psb : psa) === 1'b1) begin
        ok = 1;
        break;
      end
      step();
    end
  endtask

  // Sample n cycles starting at the current one, counting active cycles per
  // channel (pin level corrected for polarity) and period_start pulses.
  task automatic run_window(input bit sel, input int n, input int chg_at,
                            input logic [7:0] chg_val,
                            output int rc, output int gc, output int bc,
                            output int psc, output int r_last, output int g_last);
    rc = 0; gc = 0; bc = 0; psc = 0; r_last = -1; g_last = -1;
    for (int i = 0; i < n; i++) begin
      logic r, g, b, p;
      r = (sel ? rb : ra) ^ sel;
      g = (sel ? gb : ga) ^ sel;
      b = (sel ? bb : ba) ^ sel;
      p = sel ? psb : psa;
      if (r) begin rc++; r_last = i; end
      if (g) begin gc++; g_last = i; end
      if (b) bc++;
      if (p) psc++;
      if (i == chg_at) r_in = chg_val;
      step();
    end
  endtask

  initial begin
    int rc, gc, bc, psc, r_last, g_last, ok, act, pcnt;

    // Reset.
    rst = 1'b1; en = 1'b0; r_in = 8'd0; g_in = 8'd0; b_in = 8'd0;
    repeat (3) step();
    check("rst_ra", int'(ra), 0);
    check("rst_ga", int'(ga), 0);
    check("rst_ba", int'(ba), 0);
    check("rst_psa", int'(psa), 0);
    check("rst_rb_al", int'(rb), 1);
    check("rst_gb_al", int'(gb), 1);
    check("rst_bb_al", int'(bb), 1);
    check("rst_psb", int'(psb), 0);

    // Steady duties, PRESC_DIV=1.
    rst = 1'b0; r_in = 8'd64; g_in = 8'd0; b_in = 8'd255;
    step();
    en = 1'b1;
    step();
    check("en_ps_latency", int'(psa), 1);
    run_window(1'b0, 256, -1, 8'd0, rc, gc, bc, psc, r_last, g_last);
    check("steady_r_cnt", rc, 64);
    check("steady_r_last", r_last, 63);
    check("steady_g_cnt", gc, 0);
    check("steady_b_cnt", bc, 255);
    check("steady_ps_cnt", psc, 1);
    check("steady_ps_interval", int'(psa), 1);

    // Mid-period change at step 100: old duty finishes, new one next period.
    run_window(1'b0, 256, 100, 8'd192, rc, gc, bc, psc, r_last, g_last);
    check("mid_r_old_cnt", rc, 64);
    check("mid_r_old_last", r_last, 63);
    check("mid_ps_interval", int'(psa), 1);
    run_window(1'b0, 256, -1, 8'd0, rc, gc, bc, psc, r_last, g_last);
    check("mid_r_new_cnt", rc, 192);
    check("mid_r_new_last", r_last, 191);

    // Prescaler on dut_b (PRESC_DIV=4, active-low): G=128.
    g_in = 8'd128;
    wait_ps(1'b1, 1100, ok);
    check("presc_wait1", ok, 1);
    step();
    wait_ps(1'b1, 1100, ok);
    check("presc_wait2", ok, 1);
    run_window(1'b1, 1024, -1, 8'd0, rc, gc, bc, psc, r_last, g_last);
    check("presc_g_cnt", gc, 512);
    check("presc_g_last", g_last, 511);
    check("presc_ps_cnt", psc, 1);
    check("presc_ps_interval", int'(psb), 1);

    // Enable toggle on dut_a: drop at step 50.
    wait_ps(1'b0, 300, ok);
    check("en_wait_ps", ok, 1);
    repeat (50) step();
    en = 1'b0;
    step();
    check("dis_ra", int'(ra), 0);
    check("dis_ga", int'(ga), 0);
    check("dis_ba", int'(ba), 0);
    check("dis_rb_al", int'(rb), 1);
    check("dis_bb_al", int'(bb), 1);
    r_in = 8'd10;
    act = 0; pcnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (ra || ga || ba) act++;
      if (psa || psb) pcnt++;
      step();
    end
    check("dis_active", act, 0);
    check("dis_ps", pcnt, 0);
    en = 1'b1;
    step();
    check("reen_ps_latency", int'(psa), 1);
    run_window(1'b0, 256, -1, 8'd0, rc, gc, bc, psc, r_last, g_last);
    check("reen_r_cnt", rc, 10);
    check("reen_r_last", r_last, 9);

    // Reset at step 120 with B=255.
    repeat (120) step();
    check("pre_rst_ba", int'(ba), 1);
    rst = 1'b1;
    step();
    check("midrst_ba", int'(ba), 0);
    check("midrst_psa", int'(psa), 0);
    rst = 1'b0;
    step();
    check("postrst_ps", int'(psa), 1);
    run_window(1'b0, 256, -1, 8'd0, rc, gc, bc, psc, r_last, g_last);
    check("postrst_b_p1", bc, 0);
    run_window(1'b0, 256, -1, 8'd0, rc, gc, bc, psc, r_last, g_last);
    check("postrst_b_p2", bc, 255);
    check("postrst_ps_cnt", psc, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
